// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter.
// FunSel codes, flag bit positions and FSM state encoding.
package alu_arb_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

   localparam logic [3:0] FS_PASS = 4'b0000;
   localparam logic [3:0] FS_ADD  = 4'b0100;
   localparam logic [3:0] FS_ADC  = 4'b0101;
   localparam logic [3:0] FS_SUB  = 4'b0110;
   localparam int         FS_W32  = 4;

   // 32-bit pass-A: the harmless code parked on the ALU when idle
   localparam logic [4:0] FS_IDLE = {1'b1, FS_PASS};

   localparam int FLAG_Z = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_N = 1;
   localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side bundle of the ALU arbiter.
// master = requester cluster, slave = arbiter.
interface alu_arbiter_if #(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 32,
   parameter int FUNSEL_W = 5
);

   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*FUNSEL_W-1:0] req_funsel;
   logic [NUM_REQ*DATA_W-1:0]   req_a;
   logic [NUM_REQ*DATA_W-1:0]   req_b;
   logic [NUM_REQ-1:0]          req_wf;
   logic [NUM_REQ-1:0]          req_lock;
   logic [NUM_REQ-1:0]          resp_valid;
   logic [NUM_REQ-1:0]          resp_ready;
   logic [DATA_W-1:0]           resp_data;
   logic [3:0]                  resp_flags;

   modport master (
      output req_valid, req_funsel, req_a, req_b,
      output req_wf, req_lock, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_flags
   );

   modport slave (
      input  req_valid, req_funsel, req_a, req_b,
      input  req_wf, req_lock, resp_ready,
      output req_ready, resp_valid, resp_data, resp_flags
   );

endinterface

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant with last-winner pointer and owner lock.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               upd,
   input  logic               lock,
   input  logic [IDX_W-1:0]   lock_idx,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             hit;
   int               idx;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      hit     = 1'b0;
      idx     = 0;
      if (lock) begin
         if (req[lock_idx]) begin
            gnt[lock_idx] = 1'b1;
            gnt_idx       = lock_idx;
         end
      end else begin
         // search starts just after the last winner
         for (int i = 1; i <= NUM_REQ; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!hit && req[IDX_W'(idx)]) begin
               hit                = 1'b1;
               gnt[IDX_W'(idx)]   = 1'b1;
               gnt_idx            = IDX_W'(idx);
            end
         end
      end
      ptr_d = upd ? gnt_idx : ptr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= IDX_W'(NUM_REQ - 1);
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters: IDLE -> EXEC -> RESP.
// Define ALU_ARB_LOCK_EN to let an owner keep the ALU across ops.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ  = 2,
   parameter int DATA_W   = 32,
   parameter int FUNSEL_W = 5
) (
   input  logic                clk,
   input  logic                rst,
   alu_arbiter_if.slave        bus,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   output logic [FUNSEL_W-1:0] alu_funsel,
   output logic                alu_wf,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic [3:0]          alu_flags
);

   localparam int IDX_W = $clog2(NUM_REQ);

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [FUNSEL_W-1:0]  fs_q, fs_d;
   logic [DATA_W-1:0]    a_q, a_d;
   logic [DATA_W-1:0]    b_q, b_d;
   logic                 wf_q, wf_d;
   logic [DATA_W-1:0]    data_q, data_d;

   logic [NUM_REQ-1:0]   arb_req;
   logic [NUM_REQ-1:0]   gnt;
   logic [IDX_W-1:0]     gnt_idx;
   logic                 accept;
   logic                 hs;
   logic                 lock_act;

   assign arb_req = (state_q == IDLE) ? bus.req_valid : '0;
   assign accept  = |gnt;
   assign hs      = (state_q == RESP) && bus.resp_ready[owner_q];

`ifdef ALU_ARB_LOCK_EN
   logic lock_q, lock_d;
   logic lk_q, lk_d;

   // lock lapses as soon as the owner stops asking
   assign lock_act = lock_q && bus.req_valid[owner_q];

   always_comb begin
      lock_d = lock_q;
      lk_d   = lk_q;
      if (state_q == IDLE && (accept || !lock_act)) lock_d = 1'b0;
      if (accept) lk_d = bus.req_lock[gnt_idx];
      if (hs)     lock_d = lk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 1'b0;
         lk_q   <= 1'b0;
      end else begin
         lock_q <= lock_d;
         lk_q   <= lk_d;
      end
   end
`else
   logic unused_lock;

   assign lock_act    = 1'b0;
   assign unused_lock = ^bus.req_lock;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .clk      (clk),
      .rst      (rst),
      .req      (arb_req),
      .upd      (accept),
      .lock     (lock_act),
      .lock_idx (owner_q),
      .gnt      (gnt),
      .gnt_idx  (gnt_idx)
   );

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      fs_d           = fs_q;
      a_d            = a_q;
      b_d            = b_q;
      wf_d           = wf_q;
      data_d         = data_q;
      bus.req_ready  = gnt;
      bus.resp_valid = '0;
      bus.resp_flags = '0;
      alu_a          = '0;
      alu_b          = '0;
      alu_funsel     = FUNSEL_W'(FS_IDLE);
      alu_wf         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               owner_d = gnt_idx;
               fs_d    = bus.req_funsel[gnt_idx*FUNSEL_W +: FUNSEL_W];
               a_d     = bus.req_a[gnt_idx*DATA_W +: DATA_W];
               b_d     = bus.req_b[gnt_idx*DATA_W +: DATA_W];
               wf_d    = bus.req_wf[gnt_idx];
               state_d = EXEC;
            end
         end
         EXEC: begin
            alu_a      = a_q;
            alu_b      = b_q;
            alu_funsel = fs_q;
            alu_wf     = wf_q;
            data_d     = alu_out;
            state_d    = RESP;
         end
         RESP: begin
            // ALU flag register already reflects this op
            bus.resp_valid[owner_q] = 1'b1;
            bus.resp_flags          = alu_flags;
            if (hs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.resp_data = data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         fs_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         wf_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         fs_q    <= fs_d;
         a_q     <= a_d;
         b_q     <= b_d;
         wf_q    <= wf_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic
// against a transaction-level model with a stub ALU.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int FW = 5;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  fs;
      logic        wf;
      logic        lk;
   } op_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [4:0]  alu_funsel;
   logic        alu_wf;
   logic [3:0]  alu_flags = 4'h0;
   logic [35:0] alu_res;

   always #5 clk = ~clk;

   alu_arbiter_if #(.NUM_REQ(N), .DATA_W(DW), .FUNSEL_W(FW)) bus ();

   alu_arbiter #(.NUM_REQ(N), .DATA_W(DW), .FUNSEL_W(FW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_funsel (alu_funsel),
      .alu_wf     (alu_wf),
      .alu_out    (alu_out),
      .alu_flags  (alu_flags)
   );

   // reference ALU: returns {Z,C,N,O, result}
   function automatic logic [35:0] alu_fn(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [4:0]  fs,
                                          input logic        cin);
      int          w;
      logic [31:0] m, aa, bb, res;
      logic [32:0] s;
      logic        ar, c, o;
      w  = fs[FS_W32] ? 32 : 16;
      m  = fs[FS_W32] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      aa = a & m;
      bb = b & m;
      ar = 1'b1;
      case (fs[3:0])
         FS_ADD:  s = {1'b0, aa} + {1'b0, bb};
         FS_ADC:  s = {1'b0, aa} + {1'b0, bb} + {32'd0, cin};
         FS_SUB: begin
            bb = ~b & m;
            s  = {1'b0, aa} + {1'b0, bb} + 33'd1;
         end
         FS_PASS: begin s = {1'b0, aa}; ar = 1'b0; end
         default: begin s = {1'b0, aa ^ bb}; ar = 1'b0; end
      endcase
      res = s[31:0] & m;
      c   = ar && s[w];
      o   = ar && (aa[w-1] == bb[w-1]) && (res[w-1] != aa[w-1]);
      return {res == 32'd0, c, res[w-1], o, res};
   endfunction

   always_comb alu_res = alu_fn(alu_a, alu_b, alu_funsel, alu_flags[FLAG_C]);
   assign alu_out = alu_res[31:0];
   always @(posedge clk) if (alu_wf) alu_flags <= alu_res[35:32];

   int   n_vec = 0;
   int   n_err = 0;
   op_t  ops [N];
   bit   pend [N];
   int   ptr;
   bit   m_lock;
   int   m_owner;
   logic [3:0]  m_flags = 4'h0;
   logic [31:0] last_data;
   logic [3:0]  last_flags;
   int   order [$];

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic post(input int r, input op_t op);
      ops[r]  = op;
      pend[r] = 1'b1;
      bus.req_valid[r]            = 1'b1;
      bus.req_a[r*DW +: DW]       = op.a;
      bus.req_b[r*DW +: DW]       = op.b;
      bus.req_funsel[r*FW +: FW]  = op.fs;
      bus.req_wf[r]               = op.wf;
      bus.req_lock[r]             = op.lk;
   endtask

   function automatic op_t mk(input logic [4:0] fs, input logic [31:0] a,
                              input logic [31:0] b, input logic wf,
                              input logic lk);
      op_t o;
      o.fs = fs; o.a = a; o.b = b; o.wf = wf; o.lk = lk;
      return o;
   endfunction

   function automatic int pick();
      if (m_lock && pend[m_owner]) return m_owner;
      for (int i = 1; i <= N; i++)
         if (pend[(ptr + i) % N]) return (ptr + i) % N;
      return -1;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid  = '0;
      bus.resp_ready = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      ptr = N - 1; m_lock = 1'b0; m_owner = 0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_rdy", bus.req_ready, 0);
      check("rst_rvalid", bus.resp_valid, 0);
      check("rst_data", bus.resp_data, 0);
      check("rst_flags", bus.resp_flags, 0);
      check("rst_fs", alu_funsel, 5'b10000);
      check("rst_wf", alu_wf, 0);
      check("rst_ab", {alu_a, alu_b}, 0);
      @(posedge clk); #1;
   endtask

   task automatic serve(input int stall);
      int w, g;
      logic [35:0]  r;
      logic [3:0]   ef;
      logic [N-1:0] own;
      w = pick();
      if (w < 0) w = 0;
      own = '0; own[w] = 1'b1;
      r  = alu_fn(ops[w].a, ops[w].b, ops[w].fs, m_flags[FLAG_C]);
      ef = ops[w].wf ? r[35:32] : m_flags;
      @(negedge clk);
      check("grant", bus.req_ready, own);
      check("idle_wf", alu_wf, 0);
      g = -1;
      for (int i = N - 1; i >= 0; i--) if (bus.req_ready[i]) g = i;
      order.push_back(g);
      @(posedge clk); #1;
      bus.req_valid[w] = 1'b0;
      pend[w] = 1'b0;
      ptr = w;
      @(negedge clk);
      check("exec_a", alu_a, ops[w].a);
      check("exec_b", alu_b, ops[w].b);
      check("exec_fs", alu_funsel, ops[w].fs);
      check("exec_wf", alu_wf, ops[w].wf);
      check("exec_rdy", bus.req_ready, 0);
      check("exec_rv", bus.resp_valid, 0);
      @(posedge clk); #1;
      for (int s = 0; s <= stall; s++) begin
         if (s == stall) bus.resp_ready = N'($urandom) | own;
         else            bus.resp_ready = N'($urandom) & ~own;
         @(negedge clk);
         check("resp_valid", bus.resp_valid, own);
         check("resp_data", bus.resp_data, r[31:0]);
         check("resp_flags", bus.resp_flags, ef);
         check("resp_rdy", bus.req_ready, 0);
         check("resp_wf", alu_wf, 0);
         check("resp_fs", alu_funsel, 5'b10000);
         last_data  = bus.resp_data;
         last_flags = bus.resp_flags;
         @(posedge clk); #1;
      end
      bus.resp_ready = '0;
      m_flags = ef;
      m_owner = w;
`ifdef ALU_ARB_LOCK_EN
      m_lock = ops[w].lk;
`else
      m_lock = 1'b0;
`endif
   endtask

   function automatic op_t rand_op();
      logic [3:0] c;
      case ($urandom_range(4))
         0: c = FS_ADD;
         1: c = FS_ADC;
         2: c = FS_SUB;
         3: c = FS_PASS;
         default: c = 4'($urandom);
      endcase
      return mk({1'($urandom), c}, $urandom, $urandom,
                1'($urandom), $urandom_range(2) == 0);
   endfunction

   initial begin
      bus.req_valid  = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.req_funsel = '0;
      bus.req_wf     = '0;
      bus.req_lock   = '0;
      bus.resp_ready = '0;
      do_reset();

      post(0, mk(5'b10100, 32'd5, 32'd3, 1'b1, 1'b0));
      serve(0);
      check("add_data", last_data, 32'd8);
      check("add_flags", last_flags, 4'b0000);

      do_reset();
      order.delete();
      post(0, mk(5'b10100, 32'd1, 32'd2, 1'b0, 1'b0));
      post(1, mk(5'b10100, 32'd3, 32'd4, 1'b0, 1'b0));
      serve(0); serve(0);
      post(0, mk(5'b10000, 32'd9, 32'd0, 1'b0, 1'b0));
      post(1, mk(5'b10000, 32'd7, 32'd0, 1'b0, 1'b0));
      serve(0); serve(0);
      check("alternate",
            order[0] * 1000 + order[1] * 100 + order[2] * 10 + order[3],
            101);

      post(2, mk(5'b10100, 32'hDEAD, 32'h1, 1'b0, 1'b0));
      serve(3);
      check("stall_data", last_data, 32'hDEAE);

      post(1, mk(5'b10110, 32'd7, 32'd7, 1'b1, 1'b0));
      serve(1);
      check("sub_data", last_data, 32'd0);
      check("sub_z", last_flags[FLAG_Z], 1'b1);
      post(1, mk(5'b10100, 32'd1, 32'd1, 1'b0, 1'b0));
      serve(0);
      check("nowf_data", last_data, 32'd2);
      check("nowf_flags", last_flags, 4'b1100);

      post(1, mk(5'b10100, 32'd4, 32'd4, 1'b0, 1'b0));
      @(negedge clk);
      check("abort_gnt", bus.req_ready, 3'b010);
      @(posedge clk); #1;
      bus.req_valid = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      ptr = N - 1; m_lock = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_rv", bus.resp_valid, 0);
         check("abort_rdy", bus.req_ready, 0);
         check("abort_wf", alu_wf, 0);
         check("abort_fs", alu_funsel, 5'b10000);
         check("abort_data", bus.resp_data, 0);
         @(posedge clk); #1;
      end
      order.delete();
      post(0, mk(5'b10000, 32'd11, 32'd0, 1'b0, 1'b0));
      post(2, mk(5'b10000, 32'd22, 32'd0, 1'b0, 1'b0));
      serve(0); serve(0);
      check("post_rst_order", order[0] * 10 + order[1], 2);

      do_reset();
      order.delete();
      post(0, mk(5'b10100, 32'hFFFF_FFFF, 32'd1, 1'b1, 1'b1));
      post(1, mk(5'b10000, 32'd123, 32'd0, 1'b0, 1'b0));
      serve(0);
      check("lock_add", last_flags, 4'b1100);
      post(0, mk(5'b10101, 32'd0, 32'd0, 1'b1, 1'b0));
      serve(0);
`ifdef ALU_ARB_LOCK_EN
      check("adc_data", last_data, 32'd1);
      serve(0);
      check("lock_order", order[0] * 100 + order[1] * 10 + order[2], 1);
`else
      serve(0);
      check("adc_data", last_data, 32'd1);
      check("lock_order", order[0] * 100 + order[1] * 10 + order[2], 10);
`endif

      for (int it = 0; it < 150; it++) begin
         bit any;
         any = 1'b0;
         for (int r = 0; r < N; r++) begin
            if (!pend[r] && $urandom_range(1) == 1) post(r, rand_op());
            any = any | pend[r];
         end
         if (!any) post($urandom_range(N - 1), rand_op());
         serve($urandom_range(2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
